// File: rtl/divider_ctrl_fsm_if.sv
// Command handshake between the MDU command decoder (master) and the divider controller (slave).
interface divider_ctrl_fsm_if;
   logic start;
   logic usigned_n;
   logic dividend_sign;
   logic busy;
   logic done;
   logic div_by_zero;

   modport master (
      output start,
      output usigned_n,
      output dividend_sign,
      input  busy,
      input  done,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  usigned_n,
      input  dividend_sign,
      output busy,
      output done,
      output div_by_zero
   );
endinterface

// File: rtl/divider_ctrl_fsm.sv
// Sequencing controller for the carry-save SRT divider datapath: load, normalise,
// SRT iterations, conversion, sign correction and remainder de-normalisation.
module divider_ctrl_fsm #(
   parameter int PARALLELISM = 32,
   parameter int CW          = 6
) (
   input  logic              clk,
   input  logic              rst,
   divider_ctrl_fsm_if.slave cmd,
   input  logic              tc,
   input  logic              signS,
   input  logic [1:0]        magnitudeD,
   output logic              divisor_en,
   output logic              divisor_lShift,
   output logic              notDivisor_en,
   output logic              saveReminder,
   output logic              sumHMux_sel,
   output logic              sum_en,
   output logic              carry_en,
   output logic              csa_clear,
   output logic [1:0]        leftAddMux_sel,
   output logic [1:0]        rightAddMux_sel,
   output logic              QCorrectBitMux_sel,
   output logic              leftAddMode,
   output logic              rightAddMode,
   output logic              reminder_en,
   output logic              reminder_rShift,
   output logic              quotient_en,
   output logic              counterMux_sel,
   output logic              count_upDown,
   output logic              count_load,
   output logic              count_en,
   output logic              counterReg_en
);

   localparam logic [CW-1:0] NORM_MAX  = CW'(PARALLELISM);
   localparam logic [CW-1:0] ITER_LAST = CW'(PARALLELISM - 1);

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      NORM,
      ITER,
      CONV,
      CORR,
      DADJ,
      DENORM,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] iter;
   logic          busy_q;
   logic          done_q;
   logic          dbz_q;
   logic          usigned_q;
   logic          dsign_q;

   logic          unnormalised;
   logic          norm_shift;
   logic          corr_needed;

   // Divisor is normalised once its two top bits differ (01 or 10).
   assign unnormalised = (magnitudeD == 2'b00) || (magnitudeD == 2'b11);
   assign norm_shift   = unnormalised && (iter != NORM_MAX);
   // Unsigned: a negative partial remainder needs fixing; signed: it must follow the dividend sign.
   assign corr_needed  = usigned_q ? signS : (signS != dsign_q);

   assign cmd.busy        = busy_q;
   assign cmd.done        = done_q;
   assign cmd.div_by_zero = dbz_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         iter      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         usigned_q <= 1'b0;
         dsign_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd.start) begin
                  state     <= LOAD;
                  busy_q    <= 1'b1;
                  dbz_q     <= 1'b0;
                  usigned_q <= cmd.usigned_n;
                  dsign_q   <= cmd.dividend_sign;
               end
            end
            LOAD: begin
               iter  <= '0;
               state <= NORM;
            end
            NORM: begin
               if (unnormalised) begin
                  if (iter == NORM_MAX) begin
                     // Still unnormalised after a full-width scan: divisor is zero.
                     dbz_q  <= 1'b1;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     iter <= iter + 1'b1;
                  end
               end else begin
                  iter  <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               iter <= iter + 1'b1;
               if (iter == ITER_LAST) begin
                  state <= CONV;
               end
            end
            CONV: begin
               state <= CORR;
            end
            CORR: begin
               state <= usigned_q ? DENORM : DADJ;
            end
            DADJ: begin
               state <= DENORM;
            end
            DENORM: begin
               if (tc) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               iter  <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      divisor_en         = 1'b0;
      divisor_lShift     = 1'b0;
      notDivisor_en      = 1'b0;
      saveReminder       = 1'b0;
      sumHMux_sel        = 1'b0;
      sum_en             = 1'b0;
      carry_en           = 1'b0;
      csa_clear          = 1'b0;
      leftAddMux_sel     = 2'b00;
      rightAddMux_sel    = 2'b00;
      QCorrectBitMux_sel = 1'b0;
      leftAddMode        = 1'b0;
      rightAddMode       = 1'b0;
      reminder_en        = 1'b0;
      reminder_rShift    = 1'b0;
      quotient_en        = 1'b0;
      counterMux_sel     = 1'b0;
      count_upDown       = 1'b0;
      count_load         = 1'b0;
      count_en           = 1'b0;
      counterReg_en      = 1'b0;
      unique case (state)
         LOAD: begin
            divisor_en   = 1'b1;
            sumHMux_sel  = 1'b1;
            sum_en       = 1'b1;
            csa_clear    = 1'b1;
            count_load   = 1'b1;
            count_upDown = 1'b1;
         end
         NORM: begin
            count_upDown = 1'b1;
            if (norm_shift) begin
               divisor_lShift = 1'b1;
               count_en       = 1'b1;
            end else if (!unnormalised) begin
               // Counter holds s+1 here; keep it for the de-normalisation reload.
               counterReg_en = 1'b1;
               notDivisor_en = 1'b1;
            end
         end
         ITER: begin
            sum_en   = 1'b1;
            carry_en = 1'b1;
         end
         CONV: begin
            saveReminder = 1'b1;
            reminder_en  = 1'b1;
            rightAddMode = 1'b1;
            quotient_en  = 1'b1;
         end
         CORR: begin
            count_load     = 1'b1;
            counterMux_sel = 1'b1;
            if (corr_needed) begin
               // Remainder + divisor, quotient - 1.
               leftAddMux_sel  = 2'b10;
               reminder_en     = 1'b1;
               rightAddMux_sel = 2'b01;
               quotient_en     = 1'b1;
            end
         end
         DADJ: begin
            count_en = 1'b1;
         end
         DENORM: begin
            if (!tc) begin
               reminder_rShift = 1'b1;
               reminder_en     = 1'b1;
               count_en        = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_divider_ctrl_fsm.sv
// Directed bench for divider_ctrl_fsm with a small behavioural model of the divisor register and shift counter.
module tb_divider_ctrl_fsm;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tc;
   logic signS;
   logic [1:0] magnitudeD;
   logic divisor_en, divisor_lShift, notDivisor_en, saveReminder, sumHMux_sel, sum_en, carry_en, csa_clear;
   logic [1:0] leftAddMux_sel, rightAddMux_sel;
   logic QCorrectBitMux_sel, leftAddMode, rightAddMode, reminder_en, reminder_rShift, quotient_en;
   logic counterMux_sel, count_upDown, count_load, count_en, counterReg_en;

   divider_ctrl_fsm_if cmd ();

   divider_ctrl_fsm #(.PARALLELISM(32), .CW(6)) dut (
      .clk(clk), .rst(rst), .cmd(cmd), .tc(tc), .signS(signS), .magnitudeD(magnitudeD),
      .divisor_en(divisor_en), .divisor_lShift(divisor_lShift), .notDivisor_en(notDivisor_en),
      .saveReminder(saveReminder), .sumHMux_sel(sumHMux_sel), .sum_en(sum_en), .carry_en(carry_en),
      .csa_clear(csa_clear), .leftAddMux_sel(leftAddMux_sel), .rightAddMux_sel(rightAddMux_sel),
      .QCorrectBitMux_sel(QCorrectBitMux_sel), .leftAddMode(leftAddMode), .rightAddMode(rightAddMode),
      .reminder_en(reminder_en), .reminder_rShift(reminder_rShift), .quotient_en(quotient_en),
      .counterMux_sel(counterMux_sel), .count_upDown(count_upDown), .count_load(count_load),
      .count_en(count_en), .counterReg_en(counterReg_en)
   );

   always #5 clk = ~clk;

   logic [22:0] ctrl_all;
   assign ctrl_all = {divisor_en, divisor_lShift, notDivisor_en, saveReminder, sumHMux_sel, sum_en,
                      carry_en, csa_clear, leftAddMux_sel, rightAddMux_sel, QCorrectBitMux_sel,
                      leftAddMode, rightAddMode, reminder_en, reminder_rShift, quotient_en,
                      counterMux_sel, count_upDown, count_load, count_en, counterReg_en};

   // Datapath stand-in: divisor shifter and s+1 shift counter with its save register.
   logic [31:0] divisor_val = '0;
   logic        sign_s = 1'b0;
   logic [31:0] dsr = '0;
   logic [5:0]  cnt = '0;
   logic [5:0]  creg = '0;
   assign magnitudeD = dsr[31:30];
   assign tc         = (cnt == 6'd0);
   assign signS      = sign_s;

   always_ff @(posedge clk) begin
      if (divisor_en) dsr <= divisor_val;
      else if (divisor_lShift) dsr <= dsr << 1;
      if (count_load) cnt <= counterMux_sel ? creg : 6'd1;
      else if (count_en) cnt <= count_upDown ? cnt + 6'd1 : cnt - 6'd1;
      if (counterReg_en) creg <= cnt;
   end

   int n_lshift = 0, n_rshift = 0, n_iter = 0, n_dadj = 0, n_corr = 0, n_conv = 0, n_csa = 0;
   int n_accept = 0, n_overlap = 0;

   always @(negedge clk) begin
      n_lshift  <= n_lshift + int'(divisor_lShift);
      n_rshift  <= n_rshift + int'(reminder_rShift);
      n_iter    <= n_iter + int'(carry_en);
      n_dadj    <= n_dadj + int'(count_en && !count_upDown && !reminder_rShift);
      n_corr    <= n_corr + int'(leftAddMux_sel == 2'b10 && rightAddMux_sel == 2'b01 && reminder_en
                                 && quotient_en && !QCorrectBitMux_sel);
      n_conv    <= n_conv + int'(saveReminder && reminder_en && quotient_en && rightAddMode && !leftAddMode
                                 && leftAddMux_sel == 2'b00 && rightAddMux_sel == 2'b00);
      n_csa     <= n_csa + int'(csa_clear);
      n_accept  <= n_accept + int'(divisor_en);
      n_overlap <= n_overlap + int'(cmd.busy && cmd.done);
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] dvsr, input logic uns, input logic dsgn,
                         input logic ss, input int exp_lat, input int exp_l, input int exp_r,
                         input int exp_dadj, input int exp_iter, input int exp_corr, input logic exp_dbz);
      int lat, b_l, b_r, b_i, b_d, b_c, b_v, b_s, b_a;
      @(negedge clk);
      divisor_val = dvsr; sign_s = ss;
      cmd.usigned_n = uns; cmd.dividend_sign = dsgn; cmd.start = 1'b1;
      b_l = n_lshift; b_r = n_rshift; b_i = n_iter; b_d = n_dadj;
      b_c = n_corr; b_v = n_conv; b_s = n_csa; b_a = n_accept;
      @(negedge clk);
      cmd.start = 1'b0;
      check({tag, "_busy_load"}, 32'(cmd.busy), 32'd1);
      check({tag, "_dbz_cleared"}, 32'(cmd.div_by_zero), 32'd0);
      lat = 0;
      while (!cmd.done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_done"}, 32'(cmd.done), 32'd1);
      check({tag, "_busy_done"}, 32'(cmd.busy), 32'd0);
      check({tag, "_dbz"}, 32'(cmd.div_by_zero), 32'(exp_dbz));
      check({tag, "_lshift"}, 32'(n_lshift - b_l), 32'(exp_l));
      check({tag, "_rshift"}, 32'(n_rshift - b_r), 32'(exp_r));
      check({tag, "_iter"}, 32'(n_iter - b_i), 32'(exp_iter));
      check({tag, "_dadj"}, 32'(n_dadj - b_d), 32'(exp_dadj));
      check({tag, "_corr"}, 32'(n_corr - b_c), 32'(exp_corr));
      check({tag, "_conv"}, 32'(n_conv - b_v), exp_dbz ? 32'd0 : 32'd1);
      check({tag, "_csa"}, 32'(n_csa - b_s), 32'd1);
      check({tag, "_accepts"}, 32'(n_accept - b_a), 32'd1);
      @(negedge clk);
      check({tag, "_idle_ctrl"}, 32'(ctrl_all), 32'd0);
      check({tag, "_dbz_held"}, 32'(cmd.div_by_zero), 32'(exp_dbz));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, guard, lat, a0;
      cmd.start = 1'b0; cmd.usigned_n = 1'b0; cmd.dividend_sign = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(cmd.busy), 32'd0);
      check("reset_done", 32'(cmd.done), 32'd0);
      check("reset_dbz", 32'(cmd.div_by_zero), 32'd0);
      check("reset_ctrl", 32'(ctrl_all), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 100/7 unsigned: s=28, shift back s+1=29.
      run_op("u100_7", 32'd7, 1'b1, 1'b0, 1'b0, 94, 28, 29, 0, 32, 0, 1'b0);
      // -100/7 signed: DADJ once, shift back s=28.
      run_op("s100_7", 32'd7, 1'b0, 1'b1, 1'b1, 94, 28, 28, 1, 32, 0, 1'b0);
      // Remainder sign disagrees with dividend: correction cycle.
      run_op("s_corr", 32'd7, 1'b0, 1'b1, 1'b0, 94, 28, 28, 1, 32, 1, 1'b0);
      run_op("u_corr", 32'd7, 1'b1, 1'b0, 1'b1, 94, 28, 29, 0, 32, 1, 1'b0);
      // Divide by zero: 32 shifts plus detect cycle, no iterations.
      run_op("dbz", 32'd0, 1'b1, 1'b0, 1'b0, 34, 32, 0, 0, 0, 0, 1'b1);
      run_op("s_norm0", 32'h4000_0000, 1'b0, 1'b0, 1'b0, 38, 0, 0, 1, 32, 0, 1'b0);
      run_op("u_div1", 32'd1, 1'b1, 1'b0, 1'b0, 98, 30, 31, 0, 32, 0, 1'b0);

      // Reset during the tenth iteration cycle.
      @(negedge clk);
      divisor_val = 32'd10; sign_s = 1'b0;
      cmd.usigned_n = 1'b1; cmd.dividend_sign = 1'b0; cmd.start = 1'b1;
      @(negedge clk);
      cmd.start = 1'b0;
      k = 0; guard = 0;
      while (k < 10 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (carry_en) k++;
      end
      check("rst_iter_reached", 32'(k), 32'd10);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", 32'(cmd.busy), 32'd0);
      check("rst_mid_done", 32'(cmd.done), 32'd0);
      check("rst_mid_ctrl", 32'(ctrl_all), 32'd0);
      rst = 1'b0;
      run_op("u1000_10", 32'd10, 1'b1, 1'b0, 1'b0, 92, 27, 28, 0, 32, 0, 1'b0);

      // start held through an operation, still high on the done cycle.
      @(negedge clk);
      divisor_val = 32'd7; sign_s = 1'b0;
      cmd.usigned_n = 1'b1; cmd.dividend_sign = 1'b0; cmd.start = 1'b1;
      a0 = n_accept;
      lat = 0;
      @(negedge clk);
      while (!cmd.done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("hold_latency", 32'(lat), 32'd94);
      check("hold_one_accept", 32'(n_accept - a0), 32'd1);
      @(negedge clk);
      check("hold_idle_busy", 32'(cmd.busy), 32'd0);
      check("hold_idle_load", 32'(divisor_en), 32'd0);
      @(negedge clk);
      check("hold_reaccept_load", 32'(divisor_en), 32'd1);
      check("hold_reaccept_busy", 32'(cmd.busy), 32'd1);
      cmd.start = 1'b0;
      lat = 0;
      while (!cmd.done && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check("hold_second_done", 32'(cmd.done), 32'd1);
      @(negedge clk);
      check("hold_two_accepts", 32'(n_accept - a0), 32'd2);
      check("busy_done_overlap", 32'(n_overlap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
